// File: rtl/proc_trace_checker.sv
// Instruction-trace checker: compares retired instructions against a
// host-loaded expected trace and reports pass, fail or timeout.
module proc_trace_checker #(
  parameter int DEPTH = 32,
  parameter int TIMEOUT = 1024,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_val,
  input  logic [IW-1:0] load_idx,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_data,
  input  logic          load_chk,
  input  logic [IW:0]   num_entries,
  input  logic          start,
  input  logic          trace_val,
  input  logic [31:0]   trace_addr,
  input  logic [31:0]   trace_inst,
  input  logic [31:0]   trace_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW:0]   match_count,
  output logic [IW-1:0] fail_idx,
  output logic [31:0]   fail_addr,
  output logic [31:0]   fail_inst,
  output logic [31:0]   fail_data
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [IW:0] DEPTH_C = (IW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t state_q, state_d;

  logic [31:0] tab_addr [DEPTH];
  logic [31:0] tab_data [DEPTH];
  logic        tab_chk  [DEPTH];

  logic [IW:0]   cnt_q, cnt_d, cnt_clamp, mc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_d, hit;
  logic [IW-1:0] idx, fidx_d;
  logic [31:0]   faddr_d, finst_d, fdata_d;

  // match_count doubles as the index of the next expected entry
  assign idx = match_count[IW-1:0];
  assign cnt_clamp = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
  assign hit = (trace_addr == tab_addr[idx]) &&
               (!tab_chk[idx] || trace_data == tab_data[idx]);

  // table has no reset so contents survive rst and restarts
  always_ff @(posedge clk) begin
    if (load_val && state_q != RUN) begin
      tab_addr[load_idx] <= load_addr;
      tab_data[load_idx] <= load_data;
      tab_chk[load_idx]  <= load_chk;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = match_count;
    tmr_d   = tmr_q;
    to_d    = timeout;
    fidx_d  = fail_idx;
    faddr_d = fail_addr;
    finst_d = fail_inst;
    fdata_d = fail_data;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          trace_val && hit: begin
            mc_d  = match_count + 1'b1;
            tmr_d = '0;
            if (mc_d == cnt_q) state_d = PASS;
          end
          trace_val && !hit: begin
            state_d = FAIL;
            fidx_d  = idx;
            faddr_d = trace_addr;
            finst_d = trace_inst;
            fdata_d = trace_data;
          end
          !trace_val && tmr_q == TMAX: begin
            state_d = FAIL;
            to_d    = 1'b1;
            fidx_d  = idx;
            faddr_d = '0;
            finst_d = '0;
            fdata_d = '0;
          end
          default: tmr_d = tmr_q + 1'b1;
        endcase
      end
      default: begin
        if (start) begin
          cnt_d   = cnt_clamp;
          mc_d    = '0;
          tmr_d   = '0;
          to_d    = 1'b0;
          fidx_d  = '0;
          faddr_d = '0;
          finst_d = '0;
          fdata_d = '0;
          state_d = (cnt_clamp == '0) ? PASS : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      match_count <= '0;
      timeout     <= 1'b0;
      fail_idx    <= '0;
      fail_addr   <= '0;
      fail_inst   <= '0;
      fail_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      match_count <= mc_d;
      timeout     <= to_d;
      fail_idx    <= fidx_d;
      fail_addr   <= faddr_d;
      fail_inst   <= finst_d;
      fail_data   <= fdata_d;
      busy        <= state_d == RUN;
      done        <= state_d == PASS || state_d == FAIL;
      pass        <= state_d == PASS;
      fail        <= state_d == FAIL;
    end
  end

endmodule

// File: tb/tb_proc_trace_checker.sv
// Bench for proc_trace_checker: directed trace scenarios plus
// randomized runs checked against a trace-level reference model.
module tb_proc_trace_checker;

  localparam int DEPTH = 8;
  localparam int TIMEOUT = 8;
  localparam int IW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          load_val;
  logic [IW-1:0] load_idx;
  logic [31:0]   load_addr, load_data;
  logic          load_chk;
  logic [IW:0]   num_entries;
  logic          start;
  logic          trace_val;
  logic [31:0]   trace_addr, trace_inst, trace_data;
  logic          busy, done, pass, fail, timeout;
  logic [IW:0]   match_count;
  logic [IW-1:0] fail_idx;
  logic [31:0]   fail_addr, fail_inst, fail_data;

  logic [31:0] t_addr [DEPTH];
  logic [31:0] t_data [DEPTH];
  bit          t_chk  [DEPTH];

  int n_chk = 0;
  int n_pass = 0;

  proc_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .load_val(load_val), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .load_chk(load_chk),
    .num_entries(num_entries), .start(start),
    .trace_val(trace_val), .trace_addr(trace_addr),
    .trace_inst(trace_inst), .trace_data(trace_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .match_count(match_count),
    .fail_idx(fail_idx), .fail_addr(fail_addr),
    .fail_inst(fail_inst), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] a,
                      input logic [31:0] d, input bit c,
                      input bit mirror);
    load_val  = 1'b1;
    load_idx  = IW'(i);
    load_addr = a;
    load_data = d;
    load_chk  = c;
    tick();
    load_val = 1'b0;
    if (mirror) begin
      t_addr[i] = a;
      t_data[i] = d;
      t_chk[i]  = c;
    end
  endtask

  task automatic go(input int n);
    num_entries = (IW + 1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d);
    trace_val  = 1'b1;
    trace_addr = a;
    trace_data = d;
    trace_inst = $urandom;
    tick();
    trace_val = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " flags"},
          {27'd0, busy, done, pass, fail, timeout}, 32'd0);
    check({tag, " mc"}, 32'(match_count), 32'd0);
    check({tag, " fidx"}, 32'(fail_idx), 32'd0);
    check({tag, " faddr"}, fail_addr, 32'd0);
    check({tag, " finst"}, fail_inst, 32'd0);
    check({tag, " fdata"}, fail_data, 32'd0);
  endtask

  task automatic load_bne();
    load(0, 32'h000, 32'h1, 1'b1, 1'b1);
    load(1, 32'h004, 32'h2, 1'b1, 1'b1);
    load(2, 32'h008, 32'h0, 1'b0, 1'b1);
    load(3, 32'h010, 32'h3, 1'b1, 1'b1);
  endtask

  // Random run: the model walks the beat list, tracking the next
  // expected entry and the length of the current silent stretch.
  task automatic rand_run(input int r);
    int n, eff, pos, gap, fidx;
    bit fin, v_pass, v_to, hit;
    logic [31:0] fa, fi, fd;
    bit bv[$];
    logic [31:0] ba[$], bd[$], bi[$];
    bit eb[$];
    int em[$];
    n = $urandom_range(1, 2 * DEPTH - 1);
    eff = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < DEPTH; k++)
      load(k, 32'($urandom_range(0, 1023)) << 2, $urandom,
           1'($urandom_range(0, 1)), 1'b1);
    for (int k = 0; k < eff; k++) begin
      logic [31:0] a, d;
      int g;
      g = ($urandom_range(0, 11) == 0) ? TIMEOUT : $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        bv.push_back(1'b0); ba.push_back($urandom);
        bd.push_back($urandom); bi.push_back($urandom);
      end
      a = t_addr[k];
      d = t_chk[k] ? t_data[k] : $urandom;
      case ($urandom_range(0, 14))
        0: a = a ^ 32'h4;
        1: d = d ^ 32'h1;
        default: ;
      endcase
      bv.push_back(1'b1); ba.push_back(a);
      bd.push_back(d); bi.push_back($urandom);
    end
    for (int j = 0; j < 3; j++) begin
      bv.push_back(1'b1); ba.push_back($urandom);
      bd.push_back($urandom); bi.push_back($urandom);
    end
    for (int j = 0; j < TIMEOUT + 1; j++) begin
      bv.push_back(1'b0); ba.push_back(0);
      bd.push_back(0); bi.push_back(0);
    end
    pos = 0; gap = 0; fin = 0; v_pass = 0; v_to = 0;
    fidx = 0; fa = 0; fi = 0; fd = 0;
    foreach (bv[i]) begin
      if (!fin) begin
        if (bv[i]) begin
          hit = ba[i] == t_addr[pos] &&
                (!t_chk[pos] || bd[i] == t_data[pos]);
          if (hit) begin
            pos++;
            gap = 0;
            if (pos == eff) begin fin = 1; v_pass = 1; end
          end else begin
            fin = 1; fidx = pos;
            fa = ba[i]; fi = bi[i]; fd = bd[i];
          end
        end else begin
          gap++;
          if (gap == TIMEOUT) begin fin = 1; v_to = 1; fidx = pos; end
        end
      end
      eb.push_back(!fin);
      em.push_back(pos);
    end
    go(n);
    foreach (bv[i]) begin
      trace_val  = bv[i];
      trace_addr = ba[i];
      trace_data = bd[i];
      trace_inst = bi[i];
      tick();
      check($sformatf("r%0d c%0d busy", r, i), 32'(busy), 32'(eb[i]));
      check($sformatf("r%0d c%0d mc", r, i), 32'(match_count), 32'(em[i]));
    end
    trace_val = 1'b0;
    check($sformatf("r%0d pass", r), 32'(pass), 32'(v_pass));
    check($sformatf("r%0d fail", r), 32'(fail), 32'(!v_pass));
    check($sformatf("r%0d timeout", r), 32'(timeout), 32'(v_to));
    check($sformatf("r%0d fidx", r), 32'(fail_idx), 32'(fidx));
    check($sformatf("r%0d faddr", r), fail_addr, fa);
    check($sformatf("r%0d finst", r), fail_inst, fi);
    check($sformatf("r%0d fdata", r), fail_data, fd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_val = 1'b0; load_idx = '0;
    load_addr = '0; load_data = '0; load_chk = 1'b0;
    num_entries = '0; start = 1'b0; trace_val = 1'b0;
    trace_addr = '0; trace_inst = '0; trace_data = '0;
    tick(); tick();
    rst = 1'b0;
    check_cleared("reset");

    load_bne();
    go(4);
    check("bne busy", 32'(busy), 32'd1);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    tick(); tick();
    check("bne gap busy", 32'(busy), 32'd1);
    beat(32'h008, 32'h12345678);
    check("bne mc3", 32'(match_count), 32'd3);
    check("bne pass early", 32'(pass), 32'd0);
    beat(32'h010, 32'h3);
    check("bne pass", 32'(pass), 32'd1);
    check("bne mc4", 32'(match_count), 32'd4);
    check("bne fail", 32'(fail), 32'd0);
    check("bne done", 32'(done), 32'd1);

    go(4);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    beat(32'h00C, 32'h9);
    check("nt fail", 32'(fail), 32'd1);
    check("nt fidx", 32'(fail_idx), 32'd2);
    check("nt faddr", fail_addr, 32'h0000000C);
    check("nt mc", 32'(match_count), 32'd2);
    check("nt timeout", 32'(timeout), 32'd0);
    beat(32'h008, 32'h0);
    check("nt sticky fail", 32'(fail), 32'd1);
    check("nt sticky mc", 32'(match_count), 32'd2);

    go(4);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'hFFFFFFFE);
    check("dm fail", 32'(fail), 32'd1);
    check("dm fidx", 32'(fail_idx), 32'd1);
    check("dm fdata", fail_data, 32'hFFFFFFFE);
    go(4);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    beat(32'h008, 32'hDEADBEEF);
    beat(32'h010, 32'h3);
    check("dc pass", 32'(pass), 32'd1);

    go(4);
    beat(32'h000, 32'h1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("to early", 32'(fail), 32'd0);
    tick();
    check("to fail", 32'(fail), 32'd1);
    check("to flag", 32'(timeout), 32'd1);
    check("to fidx", 32'(fail_idx), 32'd1);
    check("to faddr", fail_addr, 32'd0);

    go(0);
    check("zero pass", 32'(pass), 32'd1);
    check("zero busy", 32'(busy), 32'd0);

    go(4);
    beat(32'h000, 32'h1);
    go(1);
    check("restart busy", 32'(busy), 32'd1);
    check("restart mc", 32'(match_count), 32'd1);
    load(1, 32'h44, 32'h55, 1'b1, 1'b0);
    beat(32'h004, 32'h2);
    beat(32'h008, 32'h0);
    check("restart pass early", 32'(pass), 32'd0);
    beat(32'h010, 32'h3);
    check("restart pass", 32'(pass), 32'd1);
    go(2);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    check("runload pass", 32'(pass), 32'd1);

    load_val = 1'b1; load_idx = '0;
    load_addr = 32'h100; load_data = 32'h7; load_chk = 1'b1;
    num_entries = 1; start = 1'b1;
    tick();
    load_val = 1'b0; start = 1'b0;
    t_addr[0] = 32'h100; t_data[0] = 32'h7; t_chk[0] = 1'b1;
    beat(32'h100, 32'h7);
    check("ldstart pass", 32'(pass), 32'd1);
    load(0, 32'h000, 32'h1, 1'b1, 1'b1);

    go(4);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("midrst");
    go(4);
    beat(32'h000, 32'h1);
    beat(32'h004, 32'h2);
    beat(32'h008, 32'hCAFE);
    beat(32'h010, 32'h3);
    check("retain pass", 32'(pass), 32'd1);
    check("retain mc", 32'(match_count), 32'd4);

    for (int r = 0; r < 40; r++) rand_run(r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
